// File: rtl/gb_dma_pkg.sv
// rtl/gb_dma_pkg.sv - shared types, address constants and helpers for the OAM DMA bus controller
//
// Holds the DMA state encoding, the fixed Game Boy addresses the controller
// decodes, and two small helpers used by the top level.

package gb_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR    = 16'hFF46;
    localparam logic [15:0] OAM_BASE        = 16'hFE00;
    localparam logic [15:0] HRAM_BASE       = 16'hFF80;
    localparam logic [15:0] HRAM_LAST       = 16'hFFFE;
    localparam logic [7:0]  ECHO_FIRST      = 8'hE0;
    localparam int          DMA_LEN_DEFAULT = 160;

    function automatic logic is_hram(input logic [15:0] addr);
        return (addr >= HRAM_BASE) && (addr <= HRAM_LAST);
    endfunction

    // Pages 0xE0-0xFF mirror work RAM 0x20 pages lower (echo RAM).
    function automatic logic [7:0] src_page(input logic [7:0] src);
        return (src >= ECHO_FIRST) ? (src - 8'h20) : src;
    endfunction

endpackage

// File: rtl/gb_hram.sv
// rtl/gb_hram.sv - 127-byte high RAM at 0xFF80-0xFFFE
//
// Ports:
//   clk      in   clock, writes on posedge
//   we_i     in   write enable
//   idx_i    in   7-bit byte index (address - 0xFF80)
//   wdata_i  in   write data
//   rdata_o  out  combinational read data
// Contents are not reset.

module gb_hram (
    input  logic       clk,
    input  logic       we_i,
    input  logic [6:0] idx_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [0:126];

    // Index 127 would be 0xFFFF (interrupt enable), which lives elsewhere.
    always_ff @(posedge clk) begin
        if (we_i && (idx_i != 7'h7F)) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = (idx_i != 7'h7F) ? mem_q[idx_i] : 8'hFF;

endmodule

// File: rtl/gb_oam_dma.sv
// rtl/gb_oam_dma.sv - external memory bus owner with OAM DMA engine and HRAM
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   cpu_addr_i     CPU address
//   cpu_data_i     CPU write data
//   cpu_drive_i    CPU write strobe
//   cpu_data_o     read data back to CPU (combinational)
//   mem_addr_o     external memory address
//   mem_data_o     external write data
//   mem_we_o       external write enable
//   mem_data_i     external read data (combinational from mem_addr_o)
//   dma_active_o   high while the DMA engine owns the bus

module gb_oam_dma
    import gb_dma_pkg::*;
#(
    parameter int DMA_LEN = DMA_LEN_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_drive_i,
    output logic [7:0]  cpu_data_o,
    output logic [15:0] mem_addr_o,
    output logic [7:0]  mem_data_o,
    output logic        mem_we_o,
    input  logic [7:0]  mem_data_i,
    output logic        dma_active_o
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_t state_q, state_d;
    logic [7:0] src_q, src_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] byte_q, byte_d;
    logic       dma_active_q, dma_active_d;

    logic       dma_reg_wr;
    logic       cpu_in_hram;
    logic [7:0] hram_rdata;
    logic [7:0] page;

    assign dma_reg_wr  = cpu_drive_i && (cpu_addr_i == DMA_REG_ADDR);
    assign cpu_in_hram = is_hram(cpu_addr_i);
    assign page        = src_page(src_q);

    // HRAM sits on the CPU side of the lockout, so writes always land.
    // HRAM_BASE has its low seven bits clear, so the index is just addr[6:0].
    gb_hram u_hram (
        .clk     (clk),
        .we_i    (cpu_drive_i && cpu_in_hram),
        .idx_i   (cpu_addr_i[6:0]),
        .wdata_i (cpu_data_i),
        .rdata_o (hram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        idx_d        = idx_q;
        byte_d       = byte_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_START: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                byte_d  = mem_data_i;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = 8'h00;
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A register write overrides whatever the engine was doing,
        // including the final WRITE, and restarts from index 0.
        if (dma_reg_wr) begin
            src_d   = cpu_data_i;
            idx_d   = 8'h00;
            state_d = ST_START;
        end

        dma_active_d = (state_d == ST_READ) || (state_d == ST_WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            src_q        <= 8'hFF;
            idx_q        <= 8'h00;
            byte_q       <= 8'h00;
            dma_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            idx_q        <= idx_d;
            byte_q       <= byte_d;
            dma_active_q <= dma_active_d;
        end
    end

    assign dma_active_o = dma_active_q;

    // External bus mux: CPU pass-through unless the engine owns the bus.
    always_comb begin
        mem_addr_o = cpu_addr_i;
        mem_data_o = cpu_data_i;
        mem_we_o   = cpu_drive_i && !dma_reg_wr && !cpu_in_hram;
        case (state_q)
            ST_READ: begin
                mem_addr_o = {page, idx_q};
                mem_data_o = byte_q;
                mem_we_o   = 1'b0;
            end
            ST_WRITE: begin
                mem_addr_o = OAM_BASE + {8'h00, idx_q};
                mem_data_o = byte_q;
                mem_we_o   = 1'b1;
            end
            default: begin
                mem_addr_o = cpu_addr_i;
            end
        endcase
    end

    always_comb begin
        if (cpu_addr_i == DMA_REG_ADDR) begin
            cpu_data_o = src_q;
        end else if (cpu_in_hram) begin
            cpu_data_o = hram_rdata;
        end else if (dma_active_o) begin
            cpu_data_o = 8'hFF;
        end else begin
            cpu_data_o = mem_data_i;
        end
    end

endmodule

// File: tb/tb_gb_oam_dma.sv
// tb/tb_gb_oam_dma.sv - directed self-checking bench for gb_oam_dma

module tb_gb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr_i;
    logic [7:0]  cpu_data_i;
    logic        cpu_drive_i;
    logic [7:0]  cpu_data_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_data_o;
    logic        mem_we_o;
    logic [7:0]  mem_data_i;
    logic        dma_active_o;

    always #5 clk = ~clk;

    gb_oam_dma #(.DMA_LEN(160)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_drive_i  (cpu_drive_i),
        .cpu_data_o   (cpu_data_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_we_o     (mem_we_o),
        .mem_data_i   (mem_data_i),
        .dma_active_o (dma_active_o)
    );

    // External memory: combinational read, write on posedge.
    logic [7:0] mem [0:65535];
    assign mem_data_i = mem[mem_addr_o];
    always @(posedge clk) begin
        if (mem_we_o) mem[mem_addr_o] <= mem_data_o;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int p, input int i);
        logic [7:0] b;
        b = 8'(i);
        case (p)
            0: return b ^ 8'h5A;
            1: return 8'(i * 3 + 1);
            2: return ~b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr_i  = a;
        cpu_data_i  = d;
        cpu_drive_i = 1'b1;
        tick();
        cpu_drive_i = 1'b0;
        #1;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        cpu_addr_i  = a;
        cpu_drive_i = 1'b0;
        #1;
        d = cpu_data_o;
    endtask

    task automatic fill(input logic [15:0] base, input int p);
        for (int i = 0; i < 160; i++) cpu_write(base + 16'(i), pat(p, i));
    endtask

    task automatic check_oam(input string tag, input int p);
        int errs;
        errs = 0;
        for (int i = 0; i < 160; i++) begin
            if (mem[16'hFE00 + 16'(i)] !== pat(p, i)) errs++;
        end
        check(tag, 16'(errs), 16'd0);
    endtask

    initial begin
        logic [7:0] rd;
        int first, cnt;

        reset = 1'b1;
        cpu_addr_i = 16'h0000;
        cpu_data_i = 8'h00;
        cpu_drive_i = 1'b0;
        ticks(3);
        reset = 1'b0;
        cpu_addr_i = 16'h4321;
        #1;
        check("rst_addr_pass", mem_addr_o, 16'h4321);
        check("rst_we", 16'(mem_we_o), 16'd0);
        check("rst_active", 16'(dma_active_o), 16'd0);
        cpu_read(16'hFF46, rd);
        check("rst_src", 16'(rd), 16'h00FF);

        // Idle pass-through
        cpu_addr_i = 16'hC005; cpu_data_i = 8'h12; cpu_drive_i = 1'b1;
        #1;
        check("pt_we", 16'(mem_we_o), 16'd1);
        check("pt_addr", mem_addr_o, 16'hC005);
        check("pt_data", 16'(mem_data_o), 16'h0012);
        tick();
        cpu_drive_i = 1'b0;
        check("pt_mem", 16'(mem[16'hC005]), 16'h0012);
        cpu_addr_i = 16'hFF46; cpu_data_i = 8'h55; cpu_drive_i = 1'b1;
        #1;
        check("pt_dmareg_we", 16'(mem_we_o), 16'd0);
        cpu_addr_i = 16'hFF85;
        #1;
        check("pt_hram_we", 16'(mem_we_o), 16'd0);
        cpu_drive_i = 1'b0;
        #1;
        cpu_write(16'h4321, 8'h9C);
        cpu_read(16'h4321, rd);
        check("pt_read", 16'(rd), 16'h009C);

        // Basic copy
        fill(16'hC000, 0);
        cpu_write(16'hFF46, 8'hC0);
        cpu_addr_i = 16'h0000;
        #1;
        check("start_pass_addr", mem_addr_o, 16'h0000);
        first = -1; cnt = 0;
        for (int c = 1; c <= 330; c++) begin
            if (dma_active_o) begin
                cnt++;
                if (first < 0) first = c;
            end
            if (c == 2)   check("first_read_addr", mem_addr_o, 16'hC000);
            if (c == 321) check("last_write_addr", mem_addr_o, 16'hFE9F);
            tick();
        end
        check("first_active_cycle", 16'(first), 16'd2);
        check("active_cycles", 16'(cnt), 16'd320);
        check_oam("basic_oam", 0);

        // Lockout
        cpu_write(16'hC100, 8'h11);
        cpu_write(16'hFF46, 8'hC0);
        ticks(4);
        cpu_read(16'h0000, rd);
        check("lock_read_ff", 16'(rd), 16'h00FF);
        cpu_write(16'hC100, 8'h33);
        check("lock_drop_write", 16'(mem[16'hC100]), 16'h0011);
        cpu_write(16'hFF90, 8'hA7);
        cpu_read(16'hFF90, rd);
        check("lock_hram", 16'(rd), 16'h00A7);
        cpu_read(16'hFF46, rd);
        check("lock_src", 16'(rd), 16'h00C0);
        cpu_addr_i = 16'h0000;
        ticks(330);
        check("lock_idle", 16'(dma_active_o), 16'd0);
        check("lock_mem_kept", 16'(mem[16'hC100]), 16'h0011);
        check_oam("lock_oam", 0);

        // Echo alias
        fill(16'hC100, 1);
        cpu_write(16'hFF46, 8'hE1);
        cpu_addr_i = 16'h0000;
        tick();
        check("echo_read_addr", mem_addr_o, 16'hC100);
        ticks(330);
        check_oam("echo_oam", 1);

        // Restart mid-transfer
        fill(16'hD000, 2);
        cpu_write(16'hFF46, 8'hC0);
        cpu_addr_i = 16'h0000;
        ticks(49);
        check("rs_active_before", 16'(dma_active_o), 16'd1);
        cpu_write(16'hFF46, 8'hD0);
        check("rs_gap", 16'(dma_active_o), 16'd0);
        cpu_addr_i = 16'h0000;
        tick();
        check("rs_active_after", 16'(dma_active_o), 16'd1);
        check("rs_read_addr", mem_addr_o, 16'hD000);
        ticks(330);
        check_oam("rs_oam", 2);

        // Register write on the final WRITE edge
        cpu_write(16'hFF46, 8'hE1);
        cpu_addr_i = 16'h0000;
        ticks(320);
        check("sim_last_addr", mem_addr_o, 16'hFE9F);
        check("sim_last_we", 16'(mem_we_o), 16'd1);
        check("sim_last_data", 16'(mem_data_o), 16'(pat(1, 159)));
        cpu_write(16'hFF46, 8'hC0);
        check("sim_start_gap", 16'(dma_active_o), 16'd0);
        check("sim_last_written", 16'(mem[16'hFE9F]), 16'(pat(1, 159)));
        cpu_read(16'hFF46, rd);
        check("sim_src", 16'(rd), 16'h00C0);
        cpu_addr_i = 16'h0000;
        tick();
        check("sim_restarted", 16'(dma_active_o), 16'd1);
        ticks(330);
        check_oam("sim_oam", 0);

        // Reset mid-transfer
        fill(16'hFE00, 3);
        cpu_write(16'hFF46, 8'hC0);
        cpu_addr_i = 16'h0000;
        ticks(99);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_active", 16'(dma_active_o), 16'd0);
        check("mr_we", 16'(mem_we_o), 16'd0);
        cpu_addr_i = 16'h1234;
        #1;
        check("mr_pass_addr", mem_addr_o, 16'h1234);
        cpu_read(16'hFF46, rd);
        check("mr_src", 16'(rd), 16'h00FF);
        ticks(5);
        check("mr_still_idle", 16'(dma_active_o), 16'd0);
        check("mr_oam48", 16'(mem[16'hFE30]), 16'(pat(0, 48)));
        check("mr_oam49", 16'(mem[16'hFE31]), 16'h0000);
        check("mr_oam159", 16'(mem[16'hFE9F]), 16'h0000);
        cpu_read(16'hFF90, rd);
        check("mr_hram_kept", 16'(rd), 16'h00A7);
        cpu_addr_i = 16'hC005; cpu_data_i = 8'h77; cpu_drive_i = 1'b1;
        #1;
        check("mr_pt_we", 16'(mem_we_o), 16'd1);
        cpu_drive_i = 1'b0;
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
